// File: rtl/alu_op_sequencer.sv
// Three-state sequencer (IDLE/EXEC/DONE) that drives the lab ALU mux and captures its result.
// Define ALU_OP_SEQUENCER_ZERO_FLAG_EN to add the registered 'zero' output.
module alu_op_sequencer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [1:0]       opcode,
   input  logic             op_load,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       control,
   input  logic [WIDTH-1:0] alu_result,
   output logic [WIDTH-1:0] acc,
`ifdef ALU_OP_SEQUENCER_ZERO_FLAG_EN
   output logic             zero,
`endif
   output logic             done,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [1:0]       ctrl_q, ctrl_d;
   logic             load_q, load_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         opnd_q  <= '0;
         ctrl_q  <= 2'b00;
         load_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         ctrl_q  <= ctrl_d;
         load_q  <= load_d;
         count_q <= count_d;
      end
   end

   // Operand and opcode are captured only at the accepting edge, so the ALU inputs stay stable afterwards.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      ctrl_d  = ctrl_q;
      load_d  = load_q;
      count_d = count_q;
      unique case (state_q)
         IDLE: begin
            if (op_valid) begin
               opnd_d  = operand;
               ctrl_d  = opcode;
               load_d  = op_load;
               state_d = EXEC;
            end
         end
         EXEC: begin
            acc_d   = load_q ? opnd_q : alu_result;
            state_d = DONE;
         end
         DONE: begin
            if (count_q != {CNT_W{1'b1}}) begin
               count_d = count_q + 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef ALU_OP_SEQUENCER_ZERO_FLAG_EN
   logic zero_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         zero_q <= 1'b1;
      end else if (state_q == EXEC) begin
         zero_q <= (acc_d == '0);
      end
   end

   assign zero = zero_q;
`endif

   assign op_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign alu_a    = acc_q;
   assign alu_b    = opnd_q;
   assign control  = ctrl_q;
   assign acc      = acc_q;
   assign op_count = count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU mux model; counter width 2 to reach saturation.
// Exercises the zero output when ALU_OP_SEQUENCER_ZERO_FLAG_EN is defined.
module tb_alu_op_sequencer;

   localparam int WIDTH = 8;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             op_valid;
   logic             op_ready;
   logic [1:0]       opcode;
   logic             op_load;
   logic [WIDTH-1:0] operand;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [1:0]       control;
   logic [WIDTH-1:0] alu_result;
   logic [WIDTH-1:0] acc;
   logic             done;
   logic             busy;
   logic [CNT_W-1:0] op_count;
`ifdef ALU_OP_SEQUENCER_ZERO_FLAG_EN
   logic             zero;
`endif

   int assertCount = 0;
   int failCount   = 0;

   always #5 clk = ~clk;

   alu_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk),
      .rst(rst),
      .op_valid(op_valid),
      .op_ready(op_ready),
      .opcode(opcode),
      .op_load(op_load),
      .operand(operand),
      .alu_a(alu_a),
      .alu_b(alu_b),
      .control(control),
      .alu_result(alu_result),
      .acc(acc),
`ifdef ALU_OP_SEQUENCER_ZERO_FLAG_EN
      .zero(zero),
`endif
      .done(done),
      .busy(busy),
      .op_count(op_count)
   );

   // Lab ALU result mux: A, Sum, AandB, Anot.
   always_comb begin
      alu_result = alu_a;
      case (control)
         2'b00: alu_result = alu_a;
         2'b01: alu_result = alu_a + alu_b;
         2'b10: alu_result = alu_a & alu_b;
         2'b11: alu_result = ~alu_a;
         default: alu_result = alu_a;
      endcase
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   task automatic checkIdle(input string tag, input logic [WIDTH-1:0] expAcc, input logic [CNT_W-1:0] expCount);
      checkOutput({tag, " acc"}, 32'(acc), 32'(expAcc));
      checkOutput({tag, " op_ready"}, 32'(op_ready), 32'd1);
      checkOutput({tag, " busy"}, 32'(busy), 32'd0);
      checkOutput({tag, " done"}, 32'(done), 32'd0);
      checkOutput({tag, " op_count"}, 32'(op_count), 32'(expCount));
   endtask

   // One full operation: accept edge, EXEC cycle, DONE cycle, back in IDLE.
   task automatic applyStimulus(input string tag, input logic ld, input logic [1:0] opc,
                                input logic [WIDTH-1:0] opnd, input logic [WIDTH-1:0] expAcc,
                                input logic [CNT_W-1:0] expCount);
      op_valid = 1'b1;
      op_load  = ld;
      opcode   = opc;
      operand  = opnd;
      stepClk();
      op_valid = 1'b0;
      operand  = ~opnd;
      opcode   = ~opc;
      checkOutput({tag, " exec control"}, 32'(control), 32'(opc));
      checkOutput({tag, " exec alu_b"}, 32'(alu_b), 32'(opnd));
      checkOutput({tag, " exec busy"}, 32'(busy), 32'd1);
      checkOutput({tag, " exec op_ready"}, 32'(op_ready), 32'd0);
      checkOutput({tag, " exec done"}, 32'(done), 32'd0);
      stepClk();
      checkOutput({tag, " done pulse"}, 32'(done), 32'd1);
      checkOutput({tag, " done acc"}, 32'(acc), 32'(expAcc));
      checkOutput({tag, " done op_ready"}, 32'(op_ready), 32'd0);
      checkOutput({tag, " done control hold"}, 32'(control), 32'(opc));
      stepClk();
      checkIdle({tag, " idle"}, expAcc, expCount);
      checkOutput({tag, " idle alu_b hold"}, 32'(alu_b), 32'(opnd));
   endtask

   task automatic doReset();
      rst = 1'b1;
      stepClk();
      stepClk();
      rst = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      op_valid = 1'b0;
      opcode   = 2'b00;
      op_load  = 1'b0;
      operand  = '0;

      // Reset then idle
      doReset();
      checkOutput("reset alu_b", 32'(alu_b), 32'd0);
      checkOutput("reset control", 32'(control), 32'd0);
`ifdef ALU_OP_SEQUENCER_ZERO_FLAG_EN
      checkOutput("reset zero", 32'(zero), 32'd1);
`endif
      for (int i = 0; i < 5; i++) begin
         checkIdle("idle after reset", 8'h00, 2'd0);
         stepClk();
      end

      // Load then add, then AND/NOT from F0; count saturates at 3
      applyStimulus("load 3C", 1'b1, 2'b00, 8'h3C, 8'h3C, 2'd1);
      applyStimulus("add 05", 1'b0, 2'b01, 8'h05, 8'h41, 2'd2);
      applyStimulus("load F0", 1'b1, 2'b00, 8'hF0, 8'hF0, 2'd3);
      applyStimulus("and 3C", 1'b0, 2'b10, 8'h3C, 8'h30, 2'd3);
      applyStimulus("not", 1'b0, 2'b11, 8'h00, 8'hCF, 2'd3);
      applyStimulus("select A", 1'b0, 2'b00, 8'h77, 8'hCF, 2'd3);

      // Busy rejection with op_valid held high
      doReset();
      checkIdle("pre busy test", 8'h00, 2'd0);
      op_valid = 1'b1;
      op_load  = 1'b0;
      opcode   = 2'b01;
      operand  = 8'h01;
      for (int i = 1; i <= 3; i++) begin
         stepClk();
         checkOutput("hold exec busy", 32'(busy), 32'd1);
         operand = 8'hAA;
         stepClk();
         checkOutput("hold done pulse", 32'(done), 32'd1);
         checkOutput("hold acc", 32'(acc), 32'(i));
         operand = 8'h01;
         stepClk();
         checkOutput("hold idle ready", 32'(op_ready), 32'd1);
         checkOutput("hold count", 32'(op_count), 32'(i));
      end
      op_valid = 1'b0;
      stepClk();
      checkOutput("hold released busy", 32'(busy), 32'd0);

      // Reset mid-operation
      doReset();
      op_valid = 1'b1;
      opcode   = 2'b01;
      operand  = 8'h05;
      stepClk();
      op_valid = 1'b0;
      checkOutput("midreset in exec", 32'(busy), 32'd1);
      rst = 1'b1;
      stepClk();
      rst = 1'b0;
      checkIdle("midreset after", 8'h00, 2'd0);
      for (int i = 0; i < 3; i++) begin
         stepClk();
         checkOutput("midreset no done", 32'(done), 32'd0);
      end
      checkOutput("midreset count", 32'(op_count), 32'd0);

`ifdef ALU_OP_SEQUENCER_ZERO_FLAG_EN
      applyStimulus("load FF", 1'b1, 2'b00, 8'hFF, 8'hFF, 2'd1);
      checkOutput("zero after FF", 32'(zero), 32'd0);
      applyStimulus("add wrap", 1'b0, 2'b01, 8'h01, 8'h00, 2'd2);
      checkOutput("zero after wrap", 32'(zero), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
